// File: rtl/pulse_stretcher_pkg.sv
// Shared state encodings and timing constants for the pulse stretcher and
// the timing blocks that reuse its prescaler.
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } stretch_state_e;

  localparam int CLK_DIV_1MS        = 50000;
  localparam int HOLD_TICKS_DEFAULT = 250;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pulse_stretcher_tick_prescaler.sv
// Free-running divider: tick is high for one cycle every CLK_DIV enabled cycles.
// The module is named tick_prescaler so later timing blocks can instantiate it directly.
module tick_prescaler
  import pulse_stretcher_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_1MS
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PRE_W = cnt_width(CLK_DIV);

  logic [PRE_W-1:0] pre_cnt_q;
  logic [PRE_W-1:0] pre_cnt_d;

  assign tick = enable && (pre_cnt_q == PRE_W'(CLK_DIV - 1));

  // Clear has priority so a restart always begins a full tick period.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    if (clear) begin
      pre_cnt_d = '0;
    end else if (enable) begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule

// File: rtl/pulse_stretcher.sv
// Turns a one-cycle strobe into a level held for CLK_DIV*HOLD_TICKS cycles,
// followed by a one-cycle done strobe.
//
//   state  | meaning
//   S_IDLE | waiting for pulse_in, outputs low
//   S_HOLD | stretch_out/busy high, prescaler and tick counter running
//   S_DONE | single cycle, done high; a pulse here starts a new window
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_1MS,
  parameter int HOLD_TICKS = HOLD_TICKS_DEFAULT,
  parameter int RETRIGGER  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic pulse_in,
  output logic stretch_out,
  output logic busy,
  output logic done
);

  localparam int TICK_W = cnt_width(HOLD_TICKS);

  stretch_state_e    state_q;
  stretch_state_e    state_d;
  logic [TICK_W-1:0] tick_cnt_q;
  logic [TICK_W-1:0] tick_cnt_d;
  logic              pre_clear;
  logic              tick;

  tick_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (pre_clear),
    .enable (state_q == S_HOLD),
    .tick   (tick)
  );

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    pre_clear  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pulse_in) begin
          state_d    = S_HOLD;
          tick_cnt_d = '0;
          pre_clear  = 1'b1;
        end
      end
      S_HOLD: begin
        // A retrigger outranks the terminal tick, so no done is produced.
        if (pulse_in && (RETRIGGER != 0)) begin
          tick_cnt_d = '0;
          pre_clear  = 1'b1;
        end else if (tick) begin
          if (tick_cnt_q == TICK_W'(HOLD_TICKS - 1)) begin
            state_d    = S_DONE;
            tick_cnt_d = '0;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (pulse_in) begin
          state_d    = S_HOLD;
          tick_cnt_d = '0;
          pre_clear  = 1'b1;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tick_cnt_d = '0;
        pre_clear  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign stretch_out = (state_q == S_HOLD);
  assign busy        = (state_q == S_HOLD);
  assign done        = (state_q == S_DONE);

endmodule
